// File: rtl/axis_gen_if.sv
// AXI4-Stream bus bundle used by the traffic generator and its sinks.
interface axis_gen_if #(
    parameter int DWIDTH = 32
) ();
    logic [DWIDTH-1:0]   tdata;
    logic                tvalid;
    logic                tready;
    logic [DWIDTH/8-1:0] tkeep;
    logic                tlast;

    modport master (output tdata, output tvalid, output tkeep, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_gen.sv
// AXI4-Stream traffic generator: software-armed runs of fixed-length packets with gaps.
// Define AXIS_GEN_LFSR_EN for an LFSR payload; otherwise payload is a byte counter.
module axis_gen #(
    parameter int DWIDTH   = 32,
    parameter int HAS_KEEP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] cfg_pkt_len,
    input  logic [31:0] cfg_pkt_num,
    input  logic [15:0] cfg_gap,
    axis_gen_if.master  m_axis,
    output logic        busy,
    output logic        done,
    output logic [31:0] pkt_cnt
);

    localparam int          NB   = DWIDTH / 8;
    localparam logic [31:0] NB32 = 32'(NB);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    function automatic logic [31:0] len_eff(input logic [15:0] len);
        return (len == 16'd0) ? NB32 : {16'd0, len};
    endfunction

    function automatic logic [15:0] last_beat(input logic [15:0] len);
        return 16'((len_eff(len) + NB32 - 32'd1) / NB32 - 32'd1);
    endfunction

    function automatic logic [NB-1:0] beat_keep(input logic [15:0] len, input logic is_last);
        logic [31:0]   rem;
        logic [NB-1:0] keep;
        rem  = len_eff(len) % NB32;
        keep = '1;
        if (HAS_KEEP != 0 && is_last && rem != 32'd0) begin
            for (int i = 0; i < NB; i++) keep[i] = (32'(i) < rem);
        end
        return keep;
    endfunction

`ifdef AXIS_GEN_LFSR_EN
    localparam logic [31:0] PAT_SEED = 32'hFFFF_FFFF;

    // Galois form of x^32+x^22+x^2+x+1, shifting right.
    function automatic logic [31:0] pat_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    function automatic logic [DWIDTH-1:0] pat_raw(input logic [31:0] s);
        logic [DWIDTH-1:0] d;
        for (int j = 0; j < DWIDTH; j++) d[j] = s[j % 32];
        return d;
    endfunction
`else
    localparam logic [31:0] PAT_SEED = 32'd0;

    function automatic logic [31:0] pat_step(input logic [31:0] s);
        return s + NB32;
    endfunction

    function automatic logic [DWIDTH-1:0] pat_raw(input logic [31:0] s);
        logic [DWIDTH-1:0] d;
        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'(s + 32'(i));
        return d;
    endfunction
`endif

    function automatic logic [DWIDTH-1:0] beat_data(input logic [DWIDTH-1:0] raw,
                                                    input logic [NB-1:0]     keep);
        logic [DWIDTH-1:0] d;
        for (int i = 0; i < NB; i++) d[8*i +: 8] = keep[i] ? raw[8*i +: 8] : 8'h00;
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       num_q, num_d;
    logic [15:0]       gap_q, gap_d;
    logic [31:0]       pat_q, pat_d;
    logic [15:0]       beat_q, beat_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic              done_q, done_d;
    logic              stop_pend_q, stop_pend_d;
    logic              tvalid_q, tvalid_d;
    logic [DWIDTH-1:0] tdata_q, tdata_d;
    logic [NB-1:0]     tkeep_q, tkeep_d;
    logic              tlast_q, tlast_d;

    logic              hs;
    logic              end_run;
    logic [31:0]       pkt_inc;
    logic              ld_en;
    logic [15:0]       ld_len;
    logic [15:0]       ld_idx;
    logic [31:0]       ld_pat;
    logic              ld_last;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        gap_d       = gap_q;
        pat_d       = pat_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        done_d      = done_q;
        stop_pend_d = stop_pend_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        ld_en       = 1'b0;
        ld_len      = len_q;
        ld_idx      = 16'd0;
        ld_pat      = pat_q;
        ld_last     = 1'b0;
        hs          = tvalid_q & m_axis.tready;
        pkt_inc     = pkt_cnt_q + 32'd1;
        end_run     = stop_pend_q | stop;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d       = cfg_pkt_len;
                    num_d       = cfg_pkt_num;
                    gap_d       = cfg_gap;
                    pkt_cnt_d   = 32'd0;
                    done_d      = 1'b0;
                    stop_pend_d = 1'b0;
                    ld_en       = 1'b1;
                    ld_len      = cfg_pkt_len;
                    ld_pat      = PAT_SEED;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (hs) begin
                    pat_d  = pat_step(pat_q);
                    ld_pat = pat_d;
                    if (!tlast_q) begin
                        ld_en  = 1'b1;
                        ld_idx = beat_q + 16'd1;
                    end else begin
                        pkt_cnt_d = pkt_inc;
                        if ((num_q != 32'd0 && pkt_inc == num_q) || end_run) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            tvalid_d = 1'b0;
                        end else if (gap_q != 16'd0) begin
                            // Counter starts at gap-1 so tvalid stays low for exactly gap cycles.
                            state_d   = GAP;
                            gap_cnt_d = gap_q - 16'd1;
                            tvalid_d  = 1'b0;
                        end else begin
                            ld_en = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (stop) stop_pend_d = 1'b1;
                if (end_run) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == 16'd0) begin
                    ld_en   = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output registers only change when a new beat is loaded, so they hold under backpressure.
        if (ld_en) begin
            ld_last  = (ld_idx == last_beat(ld_len));
            tkeep_d  = beat_keep(ld_len, ld_last);
            tdata_d  = beat_data(pat_raw(ld_pat), tkeep_d);
            tlast_d  = ld_last;
            tvalid_d = 1'b1;
            beat_d   = ld_idx;
            pat_d    = ld_pat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 16'd0;
            gap_cnt_q   <= 16'd0;
            pkt_cnt_q   <= 32'd0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
        end
    end

    // Run configuration and pattern state are always reloaded by start before use.
    always_ff @(posedge clk) begin
        len_q <= len_d;
        num_q <= num_d;
        gap_q <= gap_d;
        pat_q <= pat_d;
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = (state_q == SEND) || (state_q == GAP);
    assign done          = done_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_gen.sv
// Directed bench for axis_gen (DWIDTH=32, HAS_KEEP=1) with hand-computed beats.
module tb_axis_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] cfg_pkt_len;
    logic [31:0] cfg_pkt_num;
    logic [15:0] cfg_gap;
    logic        busy;
    logic        done;
    logic [31:0] pkt_cnt;

    axis_gen_if #(.DWIDTH(32)) m_axis ();

    axis_gen #(.DWIDTH(32), .HAS_KEEP(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_pkt_len (cfg_pkt_len),
        .cfg_pkt_num (cfg_pkt_num),
        .cfg_gap     (cfg_gap),
        .m_axis      (m_axis),
        .busy        (busy),
        .done        (done),
        .pkt_cnt     (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    int          q_gap[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic [31:0] num, input logic [15:0] gap);
        cfg_pkt_len = len;
        cfg_pkt_num = num;
        cfg_gap     = gap;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tvalid"}, 64'(m_axis.tvalid), 64'd0);
        chk({tag, "_tdata"},  64'(m_axis.tdata),  64'd0);
        chk({tag, "_tkeep"},  64'(m_axis.tkeep),  64'd0);
        chk({tag, "_tlast"},  64'(m_axis.tlast),  64'd0);
        chk({tag, "_busy"},   64'(busy),          64'd0);
        chk({tag, "_done"},   64'(done),          64'd0);
        chk({tag, "_pktcnt"}, 64'(pkt_cnt),       64'd0);
    endtask

    // Record accepted beats and the tvalid-low cycles preceding each, until done.
    task automatic collect(input int max_cyc);
        int low;
        low = 0;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_gap.delete();
        for (int c = 0; c < max_cyc; c++) begin
            if (done) break;
            if (m_axis.tvalid && m_axis.tready) begin
                q_data.push_back(m_axis.tdata);
                q_keep.push_back(m_axis.tkeep);
                q_last.push_back(m_axis.tlast);
                q_gap.push_back(low);
                low = 0;
            end else if (!m_axis.tvalid && busy) begin
                low++;
            end
            tick();
        end
        chk("collect_done", 64'(done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d[4];
        logic [3:0]  exp_k[4];
        logic        exp_l[4];
        int          pk_done;
        int          nb;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_pkt_len = '0; cfg_pkt_num = '0; cfg_gap = '0;
        m_axis.tready = 1'b1;
        tick(); tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

`ifndef AXIS_GEN_LFSR_EN
        // len=8, num=2, gap=0: back-to-back, counter pattern continues across packets
        exp_d = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_start(16'd8, 32'd2, 16'd0);
        chk("t1_busy_first", 64'(busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_tvalid%0d", k), 64'(m_axis.tvalid), 64'd1);
            chk($sformatf("t1_tdata%0d", k),  64'(m_axis.tdata),  64'(exp_d[k]));
            chk($sformatf("t1_tlast%0d", k),  64'(m_axis.tlast),  64'(exp_l[k]));
            tick();
            if (k == 1) chk("t1_pktcnt_mid", 64'(pkt_cnt), 64'd1);
        end
        chk("t1_done",   64'(done),          64'd1);
        chk("t1_busy",   64'(busy),          64'd0);
        chk("t1_pktcnt", 64'(pkt_cnt),       64'd2);
        chk("t1_tvalid", 64'(m_axis.tvalid), 64'd0);

        // len=5: partial last beat with keep and zeroed bytes
        exp_d = '{32'h03020100, 32'h00000004, 32'h0B0A0908, 32'h0000000C};
        exp_k = '{4'hF, 4'h1, 4'hF, 4'h1};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_start(16'd5, 32'd2, 16'd0);
        chk("t2_done_cleared", 64'(done), 64'd0);
        collect(50);
        chk("t2_nbeats", 64'(q_data.size()), 64'd4);
        for (int k = 0; k < 4 && k < q_data.size(); k++) begin
            chk($sformatf("t2_tdata%0d", k), 64'(q_data[k]), 64'(exp_d[k]));
            chk($sformatf("t2_tkeep%0d", k), 64'(q_keep[k]), 64'(exp_k[k]));
            chk($sformatf("t2_tlast%0d", k), 64'(q_last[k]), 64'(exp_l[k]));
        end
        chk("t2_pktcnt", 64'(pkt_cnt), 64'd2);

        // len=16, backpressure for 3 cycles on beat 2
        do_start(16'd16, 32'd1, 16'd0);
        tick(); tick();
        m_axis.tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_hold_tvalid%0d", k), 64'(m_axis.tvalid), 64'd1);
            chk($sformatf("t3_hold_tdata%0d", k),  64'(m_axis.tdata),  64'h0B0A0908);
            chk($sformatf("t3_hold_tkeep%0d", k),  64'(m_axis.tkeep),  64'hF);
            chk($sformatf("t3_hold_tlast%0d", k),  64'(m_axis.tlast),  64'd0);
            tick();
        end
        m_axis.tready = 1'b1;
        chk("t3_tdata2", 64'(m_axis.tdata), 64'h0B0A0908);
        tick();
        chk("t3_tdata3", 64'(m_axis.tdata), 64'h0F0E0D0C);
        chk("t3_tlast3", 64'(m_axis.tlast), 64'd1);
        tick();
        chk("t3_done",   64'(done),    64'd1);
        chk("t3_pktcnt", 64'(pkt_cnt), 64'd1);
`endif

        // len=4, num=3, gap=3: exactly 3 idle cycles between packets
        do_start(16'd4, 32'd3, 16'd3);
        collect(100);
        chk("t4_nbeats", 64'(q_data.size()), 64'd3);
        for (int k = 0; k < 3 && k < q_gap.size(); k++) begin
            chk($sformatf("t4_gap%0d", k),  64'(q_gap[k]),  (k == 0) ? 64'd0 : 64'd3);
            chk($sformatf("t4_last%0d", k), 64'(q_last[k]), 64'd1);
        end
`ifndef AXIS_GEN_LFSR_EN
        if (q_data.size() == 3) chk("t4_tdata2", 64'(q_data[2]), 64'h0B0A0908);
`endif
        chk("t4_pktcnt", 64'(pkt_cnt), 64'd3);

        // num=0, stop during first beat of packet 10
        do_start(16'd8, 32'd0, 16'd1);
        pk_done = 0;
        nb      = 0;
        for (int c = 0; c < 400; c++) begin
            if (done) break;
            if (m_axis.tvalid && m_axis.tready) begin
                if (!m_axis.tlast && pk_done == 9) stop = 1'b1;
                if (m_axis.tlast) pk_done++;
                nb++;
            end
            tick();
            stop = 1'b0;
        end
        chk("t5_done",   64'(done),    64'd1);
        chk("t5_busy",   64'(busy),    64'd0);
        chk("t5_pktcnt", 64'(pkt_cnt), 64'd10);
        chk("t5_nbeats", 64'(nb),      64'd20);

        // stop while idle has no effect on the next run
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_start(16'd4, 32'd2, 16'd0);
        collect(20);
        chk("t6_pktcnt", 64'(pkt_cnt), 64'd2);

        // reset mid-packet after one completed packet
        do_start(16'd8, 32'd0, 16'd0);
        tick(); tick(); tick();
        chk("t7_pktcnt_pre", 64'(pkt_cnt), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("t7");
        tick(); tick();
        chk("t7_idle_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("t7_idle_busy",   64'(busy),          64'd0);

`ifdef AXIS_GEN_LFSR_EN
        // LFSR payload: seed, then one Galois step of the seed
        do_start(16'd8, 32'd1, 16'd0);
        chk("t8_lfsr0", 64'(m_axis.tdata), 64'hFFFFFFFF);
        tick();
        chk("t8_lfsr1", 64'(m_axis.tdata), 64'hFFDFFFFC);
        chk("t8_last1", 64'(m_axis.tlast), 64'd1);
        tick();
        chk("t8_done",  64'(done),         64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
